serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and defaults for serial_subtractor
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    SS_IDLE = 2'd0,
    SS_RUN  = 2'd1,
    SS_DONE = 2'd2
  } ss_state_e;

  localparam int SS_WIDTH_DEF = 8;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit full subtractor cell (x - y - bi)
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference bit and borrow out for one bit position
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b, LSB first; optional ovf port via SERIAL_SUBTRACTOR_OVF_EN
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SS_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ss_state_e state, state_next;
  logic accept, step, finish;

  logic [WIDTH-1:0] ra, rb;
  // Only WIDTH-1 bits need storing: the last difference bit goes straight to diff.
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] sr_cat;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             d_bit, borrow_next;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand sign bits kept aside because ra/rb are shifted away during RUN.
  logic a_msb, b_msb;
`endif

  full_subtractor u_cell (
    .x  (ra[0]),
    .y  (rb[0]),
    .bi (borrow),
    .d  (d_bit),
    .bo (borrow_next)
  );

  assign sr_cat = {d_bit, sr};
  assign busy   = (state == SS_RUN);
  assign done   = (state == SS_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      SS_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SS_RUN;
        end
      end
      SS_RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          finish     = 1'b1;
          state_next = SS_DONE;
        end
      end
      SS_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SS_RUN;
        end else begin
          state_next = SS_IDLE;
        end
      end
      default: state_next = SS_IDLE;
    endcase
  end

  // Operand shifters, borrow, counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ra     <= '0;
      rb     <= '0;
      sr     <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      ra     <= a;
      rb     <= b;
      sr     <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
`endif
    end else if (step) begin
      ra     <= ra >> 1;
      rb     <= rb >> 1;
      borrow <= borrow_next;
      sr     <= sr_cat[WIDTH-1:1];
      if (finish) begin
        diff <= sr_cat;
        bout <= borrow_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf  <= (a_msb != b_msb) & (d_bit != a_msb);
`endif
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb[$];
  exp_t last;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.diff = x - y;
    e.bout = (x < y);
    e.ovf  = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (diff !== 8'h00) begin n_bad++; $display("FAIL reset_diff: got %h want 00", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL reset_bout: got %b want 0", bout); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [W-1:0] av [10] = '{8'h05, 8'h03, 8'h80, 8'hFF, 8'h00, 8'h7F, 8'h01, 8'h00, 8'hC3, 8'h5E};
    logic [W-1:0] bv [10] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h3C, 8'hA7};
    for (int i = 0; i < 14; i++) begin
      int   t0;
      int   lat;
      exp_t e;
      @(negedge clk);
      if (i < 10) begin a = av[i]; b = bv[i]; end
      else begin a = W'($urandom); b = W'($urandom); end
      start = 1'b1;
      sb.push_back(model(a, b));
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      a = ~a; b = ~b;
      while (!done && (cyc - t0) < 40) @(negedge clk);
      lat = cyc - t0;
      e = sb.pop_front();
      last = e;
      n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL vec%0d_latency: got %0d want 9", i, lat); end
      n_cmp++; if (diff !== e.diff) begin n_bad++; $display("FAIL vec%0d_diff: got %h want %h", i, diff, e.diff); end
      n_cmp++; if (bout !== e.bout) begin n_bad++; $display("FAIL vec%0d_bout: got %b want %b", i, bout, e.bout); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL vec%0d_busy_at_done: got %b want 0", i, busy); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      n_cmp++; if (ovf !== e.ovf) begin n_bad++; $display("FAIL vec%0d_ovf: got %b want %b", i, ovf, e.ovf); end
`endif
    end
  endtask

  task automatic test_ignore_start();
    int   t0;
    int   lat;
    exp_t e;
    @(negedge clk);
    a = 8'h5A; b = 8'h21; start = 1'b1;
    sb.push_back(model(a, b));
    t0 = cyc;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ign_busy_mid: got %b want 1", busy); end
    n_cmp++; if (diff !== last.diff) begin n_bad++; $display("FAIL ign_diff_held: got %h want %h", diff, last.diff); end
    while (!done && (cyc - t0) < 40) @(negedge clk);
    lat = cyc - t0;
    e = sb.pop_front();
    last = e;
    n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL ign_latency: got %0d want 9", lat); end
    n_cmp++; if (diff !== e.diff) begin n_bad++; $display("FAIL ign_diff: got %h want %h", diff, e.diff); end
    n_cmp++; if (bout !== e.bout) begin n_bad++; $display("FAIL ign_bout: got %b want %b", bout, e.bout); end
  endtask

  task automatic test_rst_abort();
    int   t0;
    int   lat;
    int   pulses;
    exp_t e;
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    sb.push_back(model(a, b));
    t0 = cyc;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sb.delete();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", done); end
    n_cmp++; if (diff !== 8'h00) begin n_bad++; $display("FAIL abort_diff: got %h want 00", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL abort_bout: got %b want 0", bout); end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
    @(negedge clk);
    a = 8'h20; b = 8'h07; start = 1'b1;
    sb.push_back(model(a, b));
    t0 = cyc;
    @(negedge clk); start = 1'b0;
    while (!done && (cyc - t0) < 40) @(negedge clk);
    lat = cyc - t0;
    e = sb.pop_front();
    last = e;
    n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL post_abort_latency: got %0d want 9", lat); end
    n_cmp++; if (diff !== e.diff) begin n_bad++; $display("FAIL post_abort_diff: got %h want %h", diff, e.diff); end
    n_cmp++; if (bout !== e.bout) begin n_bad++; $display("FAIL post_abort_bout: got %b want %b", bout, e.bout); end
  endtask

  task automatic test_back_to_back();
    int   t0;
    int   lat;
    exp_t e;
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    sb.push_back(model(a, b));
    t0 = cyc;
    @(negedge clk);
    a = 8'h00; b = 8'h01;
    sb.push_back(model(a, b));
    while (!done && (cyc - t0) < 40) @(negedge clk);
    lat = cyc - t0;
    e = sb.pop_front();
    n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 9", lat); end
    n_cmp++; if (diff !== e.diff) begin n_bad++; $display("FAIL b2b_first_diff: got %h want %h", diff, e.diff); end
    n_cmp++; if (bout !== e.bout) begin n_bad++; $display("FAIL b2b_first_bout: got %b want %b", bout, e.bout); end
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
    while (!done && (cyc - t0) < 60) @(negedge clk);
    lat = cyc - t0;
    e = sb.pop_front();
    n_cmp++; if (lat != 18) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 18", lat); end
    n_cmp++; if (diff !== e.diff) begin n_bad++; $display("FAIL b2b_second_diff: got %h want %h", diff, e.diff); end
    n_cmp++; if (bout !== e.bout) begin n_bad++; $display("FAIL b2b_second_bout: got %b want %b", bout, e.bout); end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    n_cmp++; if (ovf !== e.ovf) begin n_bad++; $display("FAIL b2b_second_ovf: got %b want %b", ovf, e.ovf); end
`endif
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got done=%b busy=%b want 0/0", done, busy); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_rst_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
